// File: rtl/ram_queue_pkg.sv
// Shared sizing and types for the RAM-backed queue controller.
package ram_queue_pkg;
    localparam int unsigned RAM_QUEUE_WIDTH = 109;
    localparam int unsigned RAM_QUEUE_DEPTH = 2;
    localparam int unsigned RAM_QUEUE_PTR_W = $clog2(RAM_QUEUE_DEPTH);

    typedef logic [RAM_QUEUE_PTR_W-1:0] ram_queue_ptr_t;
    typedef logic [RAM_QUEUE_WIDTH-1:0] ram_queue_data_t;
endpackage

// File: rtl/ram_queue_ptr.sv
// Wrapping queue pointer: increments modulo 2**PTR_W on i_inc.
module ram_queue_ptr
    import ram_queue_pkg::*;
#(
    parameter int unsigned PTR_W = RAM_QUEUE_PTR_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [PTR_W-1:0] o_value
);
    logic [PTR_W-1:0] r_value;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_value <= '0;
        end else if (i_inc) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign o_value = r_value;
endmodule

// File: rtl/ram_queue_ctrl.sv
// Ready/valid FIFO controller driving an external W0/R0 dual-port RAM macro.
// Define RAM_QUEUE_FLOW_EN for zero-latency pass-through when the queue is empty.
module ram_queue_ctrl
    import ram_queue_pkg::*;
#(
    parameter  int unsigned WIDTH = RAM_QUEUE_WIDTH,
    parameter  int unsigned DEPTH = RAM_QUEUE_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_bits,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_bits,
    output logic [PTR_W:0]   count,
    output logic [PTR_W-1:0] ram_W0_addr,
    output logic             ram_W0_en,
    output logic [WIDTH-1:0] ram_W0_data,
    output logic [PTR_W-1:0] ram_R0_addr,
    output logic             ram_R0_en,
    input  logic [WIDTH-1:0] ram_R0_data
);
    logic [PTR_W-1:0] w_enq_ptr;
    logic [PTR_W-1:0] w_deq_ptr;
    logic             r_maybe_full;
    logic             w_ptr_match;
    logic             w_empty;
    logic             w_full;
    logic             w_do_enq;
    logic             w_do_deq;

    assign w_ptr_match = (w_enq_ptr == w_deq_ptr);
    assign w_empty     = w_ptr_match & ~r_maybe_full;
    assign w_full      = w_ptr_match & r_maybe_full;

    assign enq_ready = ~w_full;
    assign w_do_deq  = ~w_empty & deq_ready;

`ifdef RAM_QUEUE_FLOW_EN
    // A pass-through taken by the consumer never touches the RAM or pointers.
    assign w_do_enq  = enq_valid & ~w_full & ~(w_empty & deq_ready);
    assign deq_valid = ~w_empty | enq_valid;
    assign deq_bits  = w_empty ? enq_bits : ram_R0_data;
`else
    assign w_do_enq  = enq_valid & ~w_full;
    assign deq_valid = ~w_empty;
    assign deq_bits  = ram_R0_data;
`endif

    assign ram_W0_en   = w_do_enq;
    assign ram_W0_addr = w_enq_ptr;
    assign ram_W0_data = enq_bits;
    assign ram_R0_en   = 1'b1;
    assign ram_R0_addr = w_deq_ptr;

    assign count = w_full ? (PTR_W+1)'(DEPTH) : {1'b0, w_enq_ptr - w_deq_ptr};

    ram_queue_ptr #(.PTR_W(PTR_W)) u_enq_ptr (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_inc   (w_do_enq),
        .o_value (w_enq_ptr)
    );

    ram_queue_ptr #(.PTR_W(PTR_W)) u_deq_ptr (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_inc   (w_do_deq),
        .o_value (w_deq_ptr)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_maybe_full <= 1'b0;
        end else if (w_do_enq != w_do_deq) begin
            r_maybe_full <= w_do_enq;
        end
    end
endmodule

// File: tb/tb_ram_queue_ctrl.sv
// Directed bench for ram_queue_ctrl with a behavioural model of the RAM macro.
module tb_ram_queue_ctrl;
    import ram_queue_pkg::*;

    localparam int unsigned WIDTH = RAM_QUEUE_WIDTH;
    localparam int unsigned DEPTH = RAM_QUEUE_DEPTH;
    localparam int unsigned PTR_W = $clog2(DEPTH);
`ifdef RAM_QUEUE_FLOW_EN
    localparam bit FLOW = 1'b1;
`else
    localparam bit FLOW = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset_n;
    logic             enq_valid;
    logic             enq_ready;
    logic [WIDTH-1:0] enq_bits;
    logic             deq_valid;
    logic             deq_ready;
    logic [WIDTH-1:0] deq_bits;
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] ram_W0_addr;
    logic             ram_W0_en;
    logic [WIDTH-1:0] ram_W0_data;
    logic [PTR_W-1:0] ram_R0_addr;
    logic             ram_R0_en;
    logic [WIDTH-1:0] ram_R0_data;

    logic [WIDTH-1:0] mem [DEPTH];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_W0_en) mem[ram_W0_addr] <= ram_W0_data;
    end
    assign ram_R0_data = mem[ram_R0_addr];

    ram_queue_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enq_valid   (enq_valid),
        .enq_ready   (enq_ready),
        .enq_bits    (enq_bits),
        .deq_valid   (deq_valid),
        .deq_ready   (deq_ready),
        .deq_bits    (deq_bits),
        .count       (count),
        .ram_W0_addr (ram_W0_addr),
        .ram_W0_en   (ram_W0_en),
        .ram_W0_data (ram_W0_data),
        .ram_R0_addr (ram_R0_addr),
        .ram_R0_en   (ram_R0_en),
        .ram_R0_data (ram_R0_data)
    );

    typedef struct packed {
        logic             ev;
        logic [WIDTH-1:0] eb;
        logic             dr;
        logic             er;
        logic             dv;
        logic             chk_bits;
        logic [WIDTH-1:0] db;
        logic [PTR_W:0]   cnt;
        logic             w0en;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic [WIDTH-1:0] eb, input logic dr);
        @(negedge clock);
        enq_valid = ev;
        enq_bits  = eb;
        deq_ready = dr;
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        enq_valid = 1'b0;
        enq_bits  = '0;
        deq_ready = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) mem[i] = '0;

        // Fill, full push attempt, drain, empty pop, then enqueue into an empty queue.
        vecs[0] = '{1'b1, 109'h1,    1'b0, 1'b1, FLOW, FLOW, 109'h1, 2'd0, 1'b1};
        vecs[1] = '{1'b1, 109'h2,    1'b0, 1'b1, 1'b1, 1'b1, 109'h1, 2'd1, 1'b1};
        vecs[2] = '{1'b0, 109'h0,    1'b0, 1'b0, 1'b1, 1'b1, 109'h1, 2'd2, 1'b0};
        vecs[3] = '{1'b1, 109'hDEAD, 1'b0, 1'b0, 1'b1, 1'b1, 109'h1, 2'd2, 1'b0};
        vecs[4] = '{1'b0, 109'h0,    1'b1, 1'b0, 1'b1, 1'b1, 109'h1, 2'd2, 1'b0};
        vecs[5] = '{1'b0, 109'h0,    1'b0, 1'b1, 1'b1, 1'b1, 109'h2, 2'd1, 1'b0};
        vecs[6] = '{1'b0, 109'h0,    1'b1, 1'b1, 1'b1, 1'b1, 109'h2, 2'd1, 1'b0};
        vecs[7] = '{1'b0, 109'h0,    1'b1, 1'b1, 1'b0, 1'b0, 109'h0, 2'd0, 1'b0};
        if (FLOW) begin
            vecs[8] = '{1'b1, 109'h7, 1'b1, 1'b1, 1'b1, 1'b1, 109'h7, 2'd0, 1'b0};
            vecs[9] = '{1'b0, 109'h0, 1'b1, 1'b1, 1'b0, 1'b0, 109'h0, 2'd0, 1'b0};
        end else begin
            vecs[8] = '{1'b1, 109'h5, 1'b1, 1'b1, 1'b0, 1'b0, 109'h0, 2'd0, 1'b1};
            vecs[9] = '{1'b0, 109'h0, 1'b1, 1'b1, 1'b1, 1'b1, 109'h5, 2'd1, 1'b0};
        end

        #1;
        chk("reset_enq_ready", 128'(enq_ready), 128'(1'b1));
        chk("reset_deq_valid", 128'(deq_valid), 128'(1'b0));
        chk("reset_count",     128'(count),     128'(0));
        chk("r0_en_const",     128'(ram_R0_en), 128'(1'b1));
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].ev, vecs[i].eb, vecs[i].dr);
            chk($sformatf("v%0d_enq_ready", i), 128'(enq_ready), 128'(vecs[i].er));
            chk($sformatf("v%0d_deq_valid", i), 128'(deq_valid), 128'(vecs[i].dv));
            chk($sformatf("v%0d_count", i),     128'(count),     128'(vecs[i].cnt));
            chk($sformatf("v%0d_w0_en", i),     128'(ram_W0_en), 128'(vecs[i].w0en));
            if (vecs[i].chk_bits)
                chk($sformatf("v%0d_deq_bits", i), 128'(deq_bits), 128'(vecs[i].db));
        end

        // Return to a known pointer state before the streaming run.
        drive(1'b0, '0, 1'b0);
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        drive(1'b1, 109'd1, 1'b0);
        chk("seed_w0_addr", 128'(ram_W0_addr), 128'(0));

        // Occupancy stays at one while both pointers wrap every other cycle.
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, WIDTH'(k + 1), 1'b1);
            chk($sformatf("s%0d_count", k),     128'(count),       128'(1));
            chk($sformatf("s%0d_deq_bits", k),  128'(deq_bits),    128'(k));
            chk($sformatf("s%0d_w0_addr", k),   128'(ram_W0_addr), 128'(k % 2));
            chk($sformatf("s%0d_r0_addr", k),   128'(ram_R0_addr), 128'((k - 1) % 2));
            chk($sformatf("s%0d_w0_en", k),     128'(ram_W0_en),   128'(1'b1));
        end
        drive(1'b0, '0, 1'b1);
        chk("tail_deq_bits", 128'(deq_bits), 128'(11));
        chk("tail_count",    128'(count),    128'(1));
        drive(1'b0, '0, 1'b0);
        chk("drained_valid", 128'(deq_valid), 128'(1'b0));

        // Asynchronous reset with one entry stored.
        drive(1'b1, 109'h42, 1'b0);
        drive(1'b0, '0, 1'b0);
        chk("pre_rst_count", 128'(count), 128'(1));
        reset_n = 1'b0;
        #1;
        chk("rst_deq_valid", 128'(deq_valid), 128'(1'b0));
        chk("rst_enq_ready", 128'(enq_ready), 128'(1'b1));
        chk("rst_count",     128'(count),     128'(0));
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("post_rst_w0_addr", 128'(ram_W0_addr), 128'(0));
        chk("post_rst_r0_addr", 128'(ram_R0_addr), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
